// File: rtl/iomem_dip_debounce.sv
// Debounced DIP-switch port on the picosoc iomem bus: DEB/PEND/MASK/RAW registers plus a level irq.
// One-cycle ready pulse one clk after a claimed request; at most one access per 2 clk, unclaimed addresses never answer.
// Optional MASK register and irq are built only when DIP_DEBOUNCE_IRQ_EN is defined.
module iomem_dip_debounce #(
   parameter int         N_IN         = 24,
   parameter logic [7:0] BASE_HI      = 8'h04,
   parameter int         PRESCALE     = 1024,
   parameter int         STABLE_TICKS = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [N_IN-1:0] dip_in,
   input  logic            iomem_valid,
   output logic            iomem_ready,
   input  logic [3:0]      iomem_wstrb,
   input  logic [31:0]     iomem_addr,
   input  logic [31:0]     iomem_wdata,
   output logic [31:0]     iomem_rdata,
   output logic            irq
);
   localparam int             PW       = $clog2(PRESCALE);
   localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [3:0]     CNT_LAST = 4'(STABLE_TICKS - 1);

   logic [N_IN-1:0] meta, sync, deb, pending, pend_set, pend_clr;
   logic [3:0]      cnt [N_IN];
   logic [PW-1:0]   pre_cnt;
   logic            tick;
   logic            hit, wr;
   logic [1:0]      offs;
   logic [31:0]     lane_mask, wr_bits, mask32, rd_mux;
   logic            unused_bits;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= dip_in;
         sync <= meta;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         pre_cnt <= '0;
      else if (pre_cnt == PRE_LAST)
         pre_cnt <= '0;
      else
         pre_cnt <= pre_cnt + PW'(1);
   end

   assign tick = (pre_cnt == PRE_LAST);

   always_comb begin
      pend_set = '0;
      for (int i = 0; i < N_IN; i++)
         pend_set[i] = tick && (sync[i] != deb[i]) && (cnt[i] == CNT_LAST);
   end

   // A bit only flips after STABLE_TICKS consecutive ticks of disagreement; any agreeing tick restarts the count.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         deb <= '0;
         for (int i = 0; i < N_IN; i++)
            cnt[i] <= 4'd0;
      end else if (tick) begin
         for (int i = 0; i < N_IN; i++) begin
            if (sync[i] == deb[i]) begin
               cnt[i] <= 4'd0;
            end else if (cnt[i] == CNT_LAST) begin
               deb[i] <= sync[i];
               cnt[i] <= 4'd0;
            end else begin
               cnt[i] <= cnt[i] + 4'd1;
            end
         end
      end
   end

   assign hit       = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_HI);
   assign wr        = |iomem_wstrb;
   assign offs      = iomem_addr[3:2];
   assign lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
   assign wr_bits   = iomem_wdata & lane_mask;
   assign pend_clr  = (hit && wr && offs == 2'd1) ? wr_bits[N_IN-1:0] : '0;

   // Set is OR-ed in after the clear so a change landing on the clearing edge is not lost.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         pending <= '0;
      else
         pending <= (pending & ~pend_clr) | pend_set;
   end

`ifdef DIP_DEBOUNCE_IRQ_EN
   logic [N_IN-1:0] mask;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mask <= '0;
         irq  <= 1'b0;
      end else begin
         if (hit && wr && offs == 2'd2)
            mask <= (mask & ~lane_mask[N_IN-1:0]) | wr_bits[N_IN-1:0];
         irq <= |(pending & mask);
      end
   end

   assign mask32 = 32'(mask);
`else
   assign mask32 = 32'd0;
   assign irq    = 1'b0;
`endif

   always_comb begin
      rd_mux = 32'd0;
      case (offs)
         2'd0:    rd_mux = 32'(deb);
         2'd1:    rd_mux = 32'(pending);
         2'd2:    rd_mux = mask32;
         default: rd_mux = 32'(sync);
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= 32'd0;
      end else if (hit) begin
         iomem_ready <= 1'b1;
         iomem_rdata <= rd_mux;
      end else begin
         iomem_ready <= 1'b0;
         iomem_rdata <= 32'd0;
      end
   end

   assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], wr_bits};

endmodule

// File: tb/tb_iomem_dip_debounce.sv
// Directed bench for iomem_dip_debounce: bus reads push expected rdata, a negedge monitor pops and compares.
module tb_iomem_dip_debounce;
   localparam int N_IN = 24;
`ifdef DIP_DEBOUNCE_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
`else
   localparam logic IRQ_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [N_IN-1:0] dip_in = '1;
   logic            iomem_valid = 1'b0;
   logic            iomem_ready;
   logic [3:0]      iomem_wstrb = 4'h0;
   logic [31:0]     iomem_addr = 32'd0;
   logic [31:0]     iomem_wdata = 32'd0;
   logic [31:0]     iomem_rdata;
   logic            irq;

   int              checks = 0;
   int              failures = 0;
   int              cyc;
   logic [31:0]     exp_q[$];
   string           name_q[$];

   iomem_dip_debounce #(
      .N_IN(N_IN), .BASE_HI(8'h04), .PRESCALE(4), .STABLE_TICKS(3)
   ) dut (
      .clk(clk), .resetn(resetn), .dip_in(dip_in),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   // Edge number since reset release; the prescaler ticks on edges where cyc % 4 == 0.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resetn && iomem_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready: got ready=1 with rdata %h, required no response", iomem_rdata);
         end else begin
            check(name_q.pop_front(), iomem_rdata, exp_q.pop_front());
         end
      end
   end

   task automatic bus(input string nm, input logic [31:0] a, input logic [3:0] ws,
                      input logic [31:0] wd, input logic [31:0] exp);
      int n;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clk); #1;
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wstrb = ws;
      iomem_wdata = wd;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!iomem_ready && n < 4);
      check({"lat_", nm}, 32'(n), 32'd1);
      if (!iomem_ready) begin
         void'(exp_q.pop_back());
         void'(name_q.pop_back());
      end
      iomem_valid = 1'b0;
      iomem_wstrb = 4'h0;
   endtask

   task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
      bus(nm, a, 4'h0, 32'd0, exp);
   endtask

   initial begin
      int seen;
      #1;
      check("rst_ready", 32'(iomem_ready), 32'd0);
      check("rst_rdata", iomem_rdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      rd("deb_at_once", 32'h0400_0000, 32'h0000_0000);
      repeat (30) @(posedge clk);
      rd("deb_all_ones", 32'h0400_0000, 32'h00FF_FFFF);
      rd("pend_all_ones", 32'h0400_0004, 32'h00FF_FFFF);
      rd("raw_all_ones", 32'h0400_000C, 32'h00FF_FFFF);

      bus("pend_w1c_lane1", 32'h0400_0004, 4'b0010, 32'hFFFF_FFFF, 32'h00FF_FFFF);
      rd("pend_after_lane1", 32'h0400_0004, 32'h00FF_00FF);
      bus("pend_w1c_all", 32'h0400_0004, 4'hF, 32'hFFFF_FFFF, 32'h00FF_00FF);
      rd("pend_cleared", 32'h0400_0004, 32'h0000_0000);
      bus("deb_ro_write", 32'h0400_0000, 4'hF, 32'h0000_0000, 32'h00FF_FFFF);
      rd("deb_unchanged", 32'h0400_0000, 32'h00FF_FFFF);

      @(posedge clk); #1;
      dip_in[0] = 1'b0;
      repeat (30) @(posedge clk);
      rd("deb_bit0_low", 32'h0400_0000, 32'h00FF_FFFE);
      rd("pend_bit0", 32'h0400_0004, 32'h0000_0001);

      bus("mask_write", 32'h0400_0008, 4'hF, 32'h0000_0001, 32'h0000_0000);
      check("irq_before", 32'(irq), 32'd0);
      @(posedge clk); #1;
      check("irq_rise", 32'(irq), 32'(IRQ_EN));
      rd("mask_read", 32'h0400_0008, 32'(IRQ_EN));

      // 6-clk pulse on bit5 spans at most two ticks, short of the three needed to flip.
      @(posedge clk); #1;
      dip_in[5] = 1'b0;
      @(posedge clk);
      rd("raw_glitch", 32'h0400_000C, 32'h00FF_FFDE);
      repeat (3) @(posedge clk);
      #1;
      dip_in[5] = 1'b1;
      repeat (30) @(posedge clk);
      rd("deb_after_glitch", 32'h0400_0000, 32'h00FF_FFFE);
      rd("pend_after_glitch", 32'h0400_0004, 32'h0000_0001);

      bus("pend_w1c_bit0", 32'h0400_0004, 4'h1, 32'h0000_0001, 32'h0000_0001);
      check("irq_still", 32'(irq), 32'(IRQ_EN));
      @(posedge clk); #1;
      check("irq_fall", 32'(irq), 32'd0);
      rd("pend_zero", 32'h0400_0004, 32'h0000_0000);

      // Rising bit0 right after a tick edge k0 flips deb on edge k0+12; the W1C lands on that same edge.
      while ((cyc % 4) != 0) begin
         @(posedge clk); #1;
      end
      dip_in[0] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      bus("pend_set_vs_clr", 32'h0400_0004, 4'h1, 32'h0000_0001, 32'h0000_0000);
      @(posedge clk); #1;
      check("irq_set_wins", 32'(irq), 32'(IRQ_EN));
      rd("pend_set_wins", 32'h0400_0004, 32'h0000_0001);
      rd("deb_bit0_high", 32'h0400_0000, 32'h00FF_FFFF);

      @(posedge clk); #1;
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0500_0000;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (iomem_ready) seen++;
      end
      check("unmapped_ready", 32'(seen), 32'd0);
      iomem_valid = 1'b0;

      @(posedge clk); #1;
      dip_in[3] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0400_0000;
      #2;
      resetn = 1'b0;
      #1;
      check("midrst_ready", 32'(iomem_ready), 32'd0);
      check("midrst_rdata", iomem_rdata, 32'd0);
      check("midrst_irq", 32'(irq), 32'd0);
      iomem_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      rd("deb_after_rst", 32'h0400_0000, 32'h0000_0000);
      rd("pend_after_rst", 32'h0400_0004, 32'h0000_0000);
      rd("mask_after_rst", 32'h0400_0008, 32'h0000_0000);
      repeat (30) @(posedge clk);
      rd("deb_resettle", 32'h0400_0000, 32'h00FF_FFF7);
      rd("pend_resettle", 32'h0400_0004, 32'h00FF_FFF7);
      #1;
      check("irq_masked_off", 32'(irq), 32'd0);

      repeat (2) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
